// File: rtl/fir_coeff_loader_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared types and helpers for the FIR coefficient loader.
//   - state_e          : loader FSM states (FILL, PEND, DRAIN)
//   - coeff_t          : signed coefficient at the default coefficient width
//   - coeff_frame_len  : number of beats in a well-formed coefficient frame
// Build option: define FIR_COEFF_SYM_EN for symmetric (half-length) frames.
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int COEFF_WIDTH = 16;

    typedef logic signed [COEFF_WIDTH-1:0] coeff_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PEND  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // With symmetric taps only the first half (centre included) is streamed;
    // the bank mirrors it onto the upper taps at swap time.
    function automatic int coeff_frame_len(input int num_taps);
`ifdef FIR_COEFF_SYM_EN
        return (num_taps + 1) / 2;
`else
        return num_taps;
`endif
    endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// ---------------------------------------------------------------------------
// fir_coeff_loader_if
// Coefficient stream + tap-side outputs of the FIR coefficient loader.
//   coeff_valid/coeff_ready/coeff_data/coeff_last : coefficient beat stream
//   swap_strobe : sample-boundary pulse that lets a pending frame go active
//   h_flat      : packed active coefficients, tap k at [k*DATA_WIDTH +: DATA_WIDTH]
//   pending     : complete frame waiting for swap_strobe
//   commit      : pulse, active bank was just updated
//   frame_err   : pulse, a malformed frame was discarded
// master = config/source side, slave = loader side.
// ---------------------------------------------------------------------------
interface fir_coeff_loader_if #(
    parameter int NUM_TAPS   = 8,
    parameter int DATA_WIDTH = 16
);
    logic                           coeff_valid;
    logic                           coeff_ready;
    logic [DATA_WIDTH-1:0]          coeff_data;
    logic                           coeff_last;
    logic                           swap_strobe;
    logic [NUM_TAPS*DATA_WIDTH-1:0] h_flat;
    logic                           pending;
    logic                           commit;
    logic                           frame_err;

    modport master (
        output coeff_valid, coeff_data, coeff_last, swap_strobe,
        input  coeff_ready, h_flat, pending, commit, frame_err
    );

    modport slave (
        input  coeff_valid, coeff_data, coeff_last, swap_strobe,
        output coeff_ready, h_flat, pending, commit, frame_err
    );
endinterface

// File: rtl/fir_coeff_bank.sv
// ---------------------------------------------------------------------------
// fir_coeff_bank
// Double-buffered coefficient storage: a shadow bank written one beat at a
// time and an active bank that is updated in a single edge on swap.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   wr_en_i      : write wr_data_i into shadow[wr_idx_i]
//   wr_idx_i     : shadow write index
//   wr_data_i    : coefficient to write
//   swap_i       : copy shadow into active (mirrored when symmetric)
//   h_flat_o     : packed active coefficients
// Build option: FIR_COEFF_SYM_EN mirrors the shadow half onto all taps.
// ---------------------------------------------------------------------------
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int NUM_TAPS   = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           wr_en_i,
    input  logic [$clog2(NUM_TAPS)-1:0]    wr_idx_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    input  logic                           swap_i,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] h_flat_o
);

    localparam int FRAME_LEN = coeff_frame_len(NUM_TAPS);
    localparam int IDX_W     = $clog2(NUM_TAPS);

    // Shadow only needs one entry per streamed beat.
    logic signed [DATA_WIDTH-1:0] shadow_q [FRAME_LEN];
    logic signed [DATA_WIDTH-1:0] active_q [NUM_TAPS];
    // Per-tap source selected from the shadow bank for the swap copy.
    logic signed [DATA_WIDTH-1:0] swap_src [NUM_TAPS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < FRAME_LEN; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (wr_en_i) begin
            for (int k = 0; k < FRAME_LEN; k++) begin
                if (wr_idx_i == IDX_W'(k)) begin
                    shadow_q[k] <= wr_data_i;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
`ifdef FIR_COEFF_SYM_EN
            // Upper taps reflect the lower half; the centre tap of an odd
            // length filter maps onto itself and is written once.
            localparam int SRC = (gi < FRAME_LEN) ? gi : (NUM_TAPS - 1 - gi);
`else
            localparam int SRC = gi;
`endif
            assign swap_src[gi] = shadow_q[SRC];
            assign h_flat_o[gi*DATA_WIDTH +: DATA_WIDTH] = active_q[gi];
        end
    endgenerate

    // Whole active bank changes in one edge so taps never see a mixed set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                active_q[k] <= '0;
            end
        end else if (swap_i) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                active_q[k] <= swap_src[k];
            end
        end
    end

endmodule

// File: rtl/fir_coeff_loader.sv
// ---------------------------------------------------------------------------
// fir_coeff_loader
// Accepts a framed coefficient stream into a shadow bank and promotes a
// complete, well-formed frame to the active bank on a sample-boundary strobe.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : fir_coeff_loader_if.slave (stream in, h_flat/status out)
// Build option: FIR_COEFF_SYM_EN streams only (NUM_TAPS+1)/2 beats per frame
// and mirrors them onto the upper taps.
// NUM_TAPS must be at least 2.
// ---------------------------------------------------------------------------
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int NUM_TAPS   = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fir_coeff_loader_if.slave    bus
);

    localparam int FRAME_LEN = coeff_frame_len(NUM_TAPS);
    localparam int IDX_W     = $clog2(NUM_TAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             ready_q;
    logic             pending_q;
    logic             commit_q;
    logic             frame_err_q;

    logic             beat_acc;
    logic             shadow_wr;
    logic             swap_go;

    // ready_q is a registered copy of "state != PEND", so acceptance never
    // depends combinationally on coeff_valid.
    assign beat_acc  = bus.coeff_valid && ready_q;
    assign shadow_wr = beat_acc && (state_q == FILL);
    assign swap_go   = (state_q == PEND) && bus.swap_strobe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            idx_q       <= '0;
            ready_q     <= 1'b1;
            pending_q   <= 1'b0;
            commit_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            commit_q    <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (beat_acc) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
                            if (bus.coeff_last) begin
                                state_q   <= PEND;
                                ready_q   <= 1'b0;
                                pending_q <= 1'b1;
                            end else begin
                                // Frame overran: swallow beats up to its last.
                                state_q <= DRAIN;
                            end
                        end else if (bus.coeff_last) begin
                            idx_q       <= '0;
                            frame_err_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (beat_acc && bus.coeff_last) begin
                        state_q     <= FILL;
                        frame_err_q <= 1'b1;
                    end
                end
                PEND: begin
                    if (bus.swap_strobe) begin
                        state_q   <= FILL;
                        ready_q   <= 1'b1;
                        pending_q <= 1'b0;
                        commit_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= FILL;
                    idx_q     <= '0;
                    ready_q   <= 1'b1;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    fir_coeff_bank #(
        .NUM_TAPS   (NUM_TAPS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (shadow_wr),
        .wr_idx_i  (idx_q),
        .wr_data_i (bus.coeff_data),
        .swap_i    (swap_go),
        .h_flat_o  (bus.h_flat)
    );

    assign bus.coeff_ready = ready_q;
    assign bus.pending     = pending_q;
    assign bus.commit      = commit_q;
    assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// ---------------------------------------------------------------------------
// tb_fir_coeff_loader
// Directed bench for fir_coeff_loader. A frame-level reference model (queue of
// accepted beats, judged at the last beat) is checked against the DUT on every
// cycle, and literal expectations pin the key scenarios. Default build uses
// NUM_TAPS=4; with FIR_COEFF_SYM_EN defined it uses NUM_TAPS=5.
// ---------------------------------------------------------------------------
module tb_fir_coeff_loader;
    import fir_pkg::*;

    localparam int DW = 16;
`ifdef FIR_COEFF_SYM_EN
    localparam int NT = 5;
    localparam int ML = (NT + 1) / 2;
`else
    localparam int NT = 4;
    localparam int ML = NT;
`endif
    localparam int HW = NT * DW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fir_coeff_loader_if #(.NUM_TAPS(NT), .DATA_WIDTH(DW)) bus ();

    fir_coeff_loader #(
        .NUM_TAPS   (NT),
        .DATA_WIDTH (DW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_active [NT];
    logic [DW-1:0] m_held   [ML];
    logic [DW-1:0] m_frame  [$];
    bit            m_pend;
    bit            m_commit;
    bit            m_err;

    function automatic logic [HW-1:0] model_flat();
        logic [HW-1:0] f;
        for (int k = 0; k < NT; k++) begin
            f[k*DW +: DW] = m_active[k];
        end
        return f;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pend   = 1'b0;
            m_commit = 1'b0;
            m_err    = 1'b0;
            m_frame.delete();
            for (int k = 0; k < NT; k++) m_active[k] = '0;
        end else begin
            m_commit = 1'b0;
            m_err    = 1'b0;
            if (m_pend) begin
                if (bus.swap_strobe) begin
                    for (int k = 0; k < NT; k++) begin
`ifdef FIR_COEFF_SYM_EN
                        m_active[k] = m_held[(k < NT - 1 - k) ? k : (NT - 1 - k)];
`else
                        m_active[k] = m_held[k];
`endif
                    end
                    m_pend   = 1'b0;
                    m_commit = 1'b1;
                    $display("[%0t] swap  h_flat=%h", $time, model_flat());
                end
            end else if (bus.coeff_valid) begin
                m_frame.push_back(bus.coeff_data);
                $display("[%0t] beat  n=%0d data=%h last=%b", $time,
                         m_frame.size(), bus.coeff_data, bus.coeff_last);
                if (bus.coeff_last) begin
                    if (m_frame.size() == ML) begin
                        for (int k = 0; k < ML; k++) m_held[k] = m_frame[k];
                        m_pend = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_frame.delete();
                end
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            check("cyc_ready",     bus.coeff_ready, !m_pend);
            check("cyc_pending",   bus.pending,     m_pend);
            check("cyc_commit",    bus.commit,      m_commit);
            check("cyc_frame_err", bus.frame_err,   m_err);
            check("cyc_h_flat",    bus.h_flat,      model_flat());
        end
    end

    // ---------------- stimulus ----------------
    task automatic beat(input coeff_t d, input logic l);
        bus.coeff_valid = 1'b1;
        bus.coeff_data  = d;
        bus.coeff_last  = l;
        @(posedge clk); #1;
        bus.coeff_valid = 1'b0;
        bus.coeff_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic swap_pulse();
        bus.swap_strobe = 1'b1;
        @(posedge clk); #1;
        bus.swap_strobe = 1'b0;
    endtask

    initial begin
        bus.coeff_valid = 1'b0;
        bus.coeff_data  = '0;
        bus.coeff_last  = 1'b0;
        bus.swap_strobe = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        check("rst_h_flat",    bus.h_flat,      '0);
        check("rst_ready",     bus.coeff_ready, 1'b1);
        check("rst_pending",   bus.pending,     1'b0);
        check("rst_commit",    bus.commit,      1'b0);
        check("rst_frame_err", bus.frame_err,   1'b0);

`ifdef FIR_COEFF_SYM_EN
        beat(16'd1, 1'b0);
        beat(16'd2, 1'b0);
        beat(16'd3, 1'b1);
        check("sym_pending", bus.pending, 1'b1);
        swap_pulse();
        check("sym_commit", bus.commit, 1'b1);
        check("sym_h_flat", bus.h_flat, 80'h0001_0002_0003_0002_0001);
`else
        // Nominal frame, strobe in the third pending cycle.
        beat(16'h0100, 1'b0);
        beat(16'h0200, 1'b0);
        beat(16'hFF00, 1'b0);
        beat(16'h0040, 1'b1);
        check("nom_pending_lat", bus.pending,     1'b1);
        check("nom_ready_low",   bus.coeff_ready, 1'b0);
        idle(2);
        check("nom_pending_c3",  bus.pending,     1'b1);
        check("nom_h_flat_old",  bus.h_flat,      '0);
        swap_pulse();
        check("nom_commit",      bus.commit,      1'b1);
        check("nom_h_flat",      bus.h_flat,      64'h0040_FF00_0200_0100);
        check("nom_pending_clr", bus.pending,     1'b0);
        check("nom_ready_back",  bus.coeff_ready, 1'b1);
        idle(1);
        check("nom_commit_once", bus.commit,      1'b0);

        // Short frame.
        beat(16'h1111, 1'b0);
        beat(16'h2222, 1'b1);
        check("short_err",     bus.frame_err, 1'b1);
        check("short_pending", bus.pending,   1'b0);
        check("short_h_flat",  bus.h_flat,    64'h0040_FF00_0200_0100);
        idle(1);
        check("short_err_once", bus.frame_err, 1'b0);

        // Long frame: error only after the sixth (last) beat.
        for (int i = 1; i <= 6; i++) begin
            beat(coeff_t'(16'h0A00 + i), (i == 6));
            if (i == 5) check("long_no_err_early", bus.frame_err, 1'b0);
        end
        check("long_err",     bus.frame_err, 1'b1);
        check("long_pending", bus.pending,   1'b0);
        check("long_h_flat",  bus.h_flat,    64'h0040_FF00_0200_0100);

        // Strobe coincident with the last beat is not a swap.
        beat(16'h0011, 1'b0);
        beat(16'h0022, 1'b0);
        beat(16'h0033, 1'b0);
        bus.swap_strobe = 1'b1;
        beat(16'h0044, 1'b1);
        bus.swap_strobe = 1'b0;
        check("sim_pending",  bus.pending, 1'b1);
        check("sim_commit",   bus.commit,  1'b0);
        check("sim_h_flat",   bus.h_flat,  64'h0040_FF00_0200_0100);
        idle(1);
        swap_pulse();
        check("sim_commit2",  bus.commit,  1'b1);
        check("sim_h_flat2",  bus.h_flat,  64'h0044_0033_0022_0011);

        // Back-pressure while pending.
        beat(16'h0005, 1'b0);
        beat(16'h0006, 1'b0);
        beat(16'h0007, 1'b0);
        beat(16'h0008, 1'b1);
        bus.coeff_valid = 1'b1;
        bus.coeff_data  = 16'h7777;
        bus.coeff_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_ready_low", bus.coeff_ready, 1'b0);
        end
        bus.coeff_valid = 1'b0;
        bus.coeff_last  = 1'b0;
        swap_pulse();
        check("bp_h_flat",    bus.h_flat,      64'h0008_0007_0006_0005);
        check("bp_ready",     bus.coeff_ready, 1'b1);
        check("bp_frame_err", bus.frame_err,   1'b0);

        // Next frame begins immediately after the swap; reset mid-frame.
        beat(16'hAAAA, 1'b0);
        beat(16'hBBBB, 1'b0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_h_flat",  bus.h_flat,      '0);
        check("mid_rst_ready",   bus.coeff_ready, 1'b1);
        check("mid_rst_pending", bus.pending,     1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        beat(16'h0001, 1'b0);
        beat(16'h0002, 1'b0);
        beat(16'h0003, 1'b0);
        beat(16'h0004, 1'b1);
        check("post_rst_pending", bus.pending, 1'b1);
        swap_pulse();
        check("post_rst_h_flat",  bus.h_flat,  64'h0004_0003_0002_0001);
`endif
        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Streams filter coefficients into a double-buffered register bank and drives the `h_in` inputs of a chain of FIR taps. Coefficients arrive as a valid/ready stream framed by a `last` flag and are written into a shadow bank. A completed, well-formed frame is copied into the active bank only on a sample-boundary strobe, so the taps never see a partially updated coefficient set. The block sits between the control/config path and the FIR tap chain.

## Interface
- `NUM_TAPS`, default 8: number of taps driven; must be ≥ 2.
- `DATA_WIDTH`, default 16: coefficient width, signed Q(DATA_WIDTH-DATA_WIDTH_F).DATA_WIDTH_F.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `coeff_valid`  in  1: the upstream source has a coefficient beat on `coeff_data`.
- `coeff_ready`  out  1: the loader accepts the beat this cycle.
- `coeff_data`  in  DATA_WIDTH: signed coefficient; beat k goes to tap k.
- `coeff_last`  in  1: marks the final beat of a frame.
- `swap_strobe`  in  1: sample-boundary pulse; allows the pending shadow bank to become active.
- `h_flat`  out  NUM_TAPS*DATA_WIDTH: active coefficients; tap k is at bits [k*DATA_WIDTH +: DATA_WIDTH].
- `pending`  out  1: a complete frame is waiting for `swap_strobe`.
- `commit`  out  1: one-cycle pulse in the cycle after the active bank was updated.
- `frame_err`  out  1: one-cycle pulse when a malformed frame is discarded.

## Operation
- Frame length L is NUM_TAPS, or (NUM_TAPS+1)/2 when symmetric mode is enabled (see Configuration).
- A beat is accepted when `coeff_valid && coeff_ready`.
- A write index `idx` (width $clog2(NUM_TAPS)) addresses the shadow bank. It increments on each accepted beat and clears at frame end.
- FSM states:
  - FILL: `coeff_ready`=1. Each accepted beat writes shadow[idx].
    - Accepted beat with `coeff_last` and idx==L-1: go to PEND, clear idx.
    - Accepted beat with `coeff_last` and idx<L-1 (short frame): stay in FILL, clear idx, pulse `frame_err`. The shadow contents are don't-care.
    - Accepted beat without `coeff_last` at idx==L-1 (long frame): go to DRAIN, clear idx.
  - DRAIN: `coeff_ready`=1. Beats are accepted and discarded. On an accepted beat with `coeff_last`: go to FILL and pulse `frame_err`.
  - PEND: `coeff_ready`=0 and `pending`=1. When `swap_strobe` is high, copy shadow to active (all taps in the same edge), go to FILL, and pulse `commit` in the next cycle.
- `swap_strobe` is ignored in FILL and DRAIN. The active bank is only ever changed by the PEND-state swap.
- A frame of a single beat is legal only when L==1, which cannot occur because NUM_TAPS ≥ 2.

## Timing
- Reset values: FSM=FILL, idx=0, shadow=0, active=0 (`h_flat`=0), `pending`=0, `commit`=0, `frame_err`=0. `coeff_ready`=1 in the first cycle after reset deasserts.
- Reset asserted mid-frame or in PEND: all state returns to its reset value immediately. The partial frame is lost and the active bank is zeroed.
- `coeff_ready` is a function of state only, with no combinational path from `coeff_valid`.
- Latency from accepting the last beat to `pending`=1: 1 cycle.
- `swap_strobe` in the same cycle as the last beat is accepted: no swap. The swap occurs on the first `swap_strobe` seen while in PEND.
- Latency from `swap_strobe` (in PEND) to new `h_flat`: 1 cycle. `commit` is high in that same cycle.
- Earliest acceptance of the next frame's first beat: the cycle after the swap (FILL entered, `coeff_ready`=1).
- `frame_err` is high in the cycle after the offending beat is accepted. `commit` and `frame_err` never assert together.

## Configuration
- `FIR_COEFF_SYM_EN` defined:
  - L=(NUM_TAPS+1)/2.
  - On swap, active[k] = shadow[k] and active[NUM_TAPS-1-k] = shadow[k] for k < L.
  - For odd NUM_TAPS, the centre tap is written once.
- `FIR_COEFF_SYM_EN` undefined: L=NUM_TAPS with a direct copy. The mirroring logic is absent.

## Structure
- Shared package `fir_pkg` holds:
  - the FSM state enum (FILL, PEND, DRAIN);
  - the function `coeff_frame_len(NUM_TAPS)` that returns L under the macro;
  - the coefficient typedef `coeff_t` (signed [DATA_WIDTH-1:0]).
- One sub-module is natural: `fir_coeff_bank`. It holds the shadow and active register arrays, the write port, the swap and mirror copy, and the `h_flat` packing. The FSM, index and handshake stay in `fir_coeff_loader`.

## Test plan
- All cases use NUM_TAPS=4 with the macro off unless stated.
- Reset: `reset_n`=0 mid-frame after 2 beats → `h_flat`=0, `coeff_ready`=1, `pending`=0. A following 4-beat frame loads normally.
- Nominal: beats 0x0100, 0x0200, 0xFF00, 0x0040 with `last` on beat 4, then `swap_strobe` 3 cycles later → `pending` high for 3 cycles, `commit` pulse, `h_flat`={0x0040,0xFF00,0x0200,0x0100}.
- Short frame: 2 beats with `last` on beat 2 → `frame_err` pulse, no `pending`, `h_flat` unchanged.
- Long frame: 6 beats with `last` on beat 6 → `frame_err` pulse after beat 6, no `pending`, `h_flat` unchanged.
- Backpressure and simultaneity:
  - `swap_strobe` high in the same cycle as the last beat → no swap that cycle; swap on the next strobe.
  - In PEND, `coeff_valid`=1 held for 5 cycles → `coeff_ready`=0 and no beats are accepted.
- Macro on: NUM_TAPS=5, beats 1,2,3 with `last` on beat 3, then swap → `h_flat` taps = 1,2,3,2,1.
